// File: rtl/cruise_pkg.sv
// Shared types, widths and saturating helpers for the cruise controller.
package cruise_pkg;

    localparam int SPEED_W  = 8;
    localparam int FUEL_W   = 4;
    localparam int LAW_W    = 11;
    localparam int FUEL_MAX = (1 << FUEL_W) - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CRUISE  = 2'd1,
        SUSPEND = 2'd2
    } state_t;

    // Saturate a signed fuel-law result into the unsigned fuel command range.
    function automatic logic [FUEL_W-1:0] clamp_fuel(input logic signed [LAW_W-1:0] f);
        logic signed [LAW_W-1:0] hi;
        hi = LAW_W'(FUEL_MAX);
        if (f < 0) begin
            return '0;
        end else if (f > hi) begin
            return FUEL_W'(FUEL_MAX);
        end else begin
            return f[FUEL_W-1:0];
        end
    endfunction

    // Saturate a signed, widened speed value into [lo, hi].
    function automatic logic [SPEED_W-1:0] clamp_speed(
        input logic signed [SPEED_W+1:0] v,
        input logic        [SPEED_W-1:0] lo,
        input logic        [SPEED_W-1:0] hi
    );
        if (v < $signed({2'b00, lo})) begin
            return lo;
        end else if (v > $signed({2'b00, hi})) begin
            return hi;
        end else begin
            return v[SPEED_W-1:0];
        end
    endfunction

endpackage

// File: rtl/cruise_fuel_law.sv
// Proportional fuel law: fuel = clamp(BASE_FUEL + ((target - speed) >>> GAIN_SHIFT), 0, 15).
// Purely combinational; the controller decides when the result is latched.
module cruise_fuel_law
    import cruise_pkg::*;
#(
    parameter int unsigned BASE_FUEL  = 4,
    parameter int unsigned GAIN_SHIFT = 1
) (
    input  logic [SPEED_W-1:0] target,
    input  logic [SPEED_W-1:0] speed,
    output logic [FUEL_W-1:0]  fuel
);

    logic signed [SPEED_W:0]   err;
    logic signed [LAW_W-1:0]   err_ext;
    logic signed [LAW_W-1:0]   err_scaled;
    logic signed [LAW_W-1:0]   f;

    // Error is formed at 9 bits so the full +/-255 span is exact, then widened
    // before the shift and offset so the sum can never wrap ahead of the clamp.
    always_comb begin
        err        = $signed({1'b0, target}) - $signed({1'b0, speed});
        err_ext    = {{(LAW_W-SPEED_W-1){err[SPEED_W]}}, err};
        err_scaled = err_ext >>> GAIN_SHIFT;
        f          = err_scaled + $signed(LAW_W'(BASE_FUEL));
        fuel       = clamp_fuel(f);
    end

endmodule

// File: rtl/cruise_controller.sv
// Cruise controller: button FSM (IDLE / CRUISE / SUSPEND), target register,
// fuel update timer and registered fuel command closing the speed loop.
module cruise_controller
    import cruise_pkg::*;
#(
    parameter int unsigned UPDATE_CYCLES = 16,
    parameter int unsigned BASE_FUEL     = 4,
    parameter int unsigned GAIN_SHIFT    = 1,
    parameter int unsigned STEP          = 2,
    parameter int unsigned MIN_SPEED     = 30,
    parameter int unsigned MAX_SPEED     = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SPEED_W-1:0] current_speed,
    input  logic               set,
    input  logic               resume,
    input  logic               cancel,
    input  logic               brake,
    input  logic               inc,
    input  logic               dec,
    output logic [FUEL_W-1:0]  fuel,
    output logic [SPEED_W-1:0] target_speed,
    output logic               engaged,
    output logic               fuel_upd
);

    localparam int TIMER_W = (UPDATE_CYCLES > 2) ? $clog2(UPDATE_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(UPDATE_CYCLES - 1);
    localparam logic [SPEED_W-1:0] MIN_SPD    = SPEED_W'(MIN_SPEED);
    localparam logic [SPEED_W-1:0] MAX_SPD    = SPEED_W'(MAX_SPEED);
    localparam logic [FUEL_W-1:0]  BASE_CMD   = FUEL_W'(BASE_FUEL);

    state_t               state;
    state_t               state_nxt;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_nxt;
    logic [SPEED_W-1:0]   target_nxt;
    logic [FUEL_W-1:0]    fuel_nxt;
    logic                 fuel_upd_nxt;
    logic [FUEL_W-1:0]    law_fuel;

    logic                 speed_ok;
    logic                 set_go;
    logic                 adjust;
    logic                 entering;
    logic                 recapture;
    logic                 terminal;
    logic [SPEED_W-1:0]   target_up;
    logic [SPEED_W-1:0]   target_dn;

    cruise_fuel_law #(
        .BASE_FUEL  (BASE_FUEL),
        .GAIN_SHIFT (GAIN_SHIFT)
    ) u_fuel_law (
        .target (target_speed),
        .speed  (current_speed),
        .fuel   (law_fuel)
    );

    // Qualified button events, decoded once so FSM and datapath agree on priority
    // (cancel > brake > set > resume > inc/dec). A pressed set occupies its priority
    // slot even when the speed is out of range, so it masks resume and inc/dec.
    always_comb begin
        speed_ok  = (current_speed >= MIN_SPD) && (current_speed <= MAX_SPD);
        set_go    = !cancel && !brake && set && speed_ok;
        adjust    = (state == CRUISE) && !cancel && !brake && !set && !resume && (inc ^ dec);
        target_up = clamp_speed($signed({2'b00, target_speed}) + $signed((SPEED_W+2)'(STEP)),
                                MIN_SPD, MAX_SPD);
        target_dn = clamp_speed($signed({2'b00, target_speed}) - $signed((SPEED_W+2)'(STEP)),
                                MIN_SPD, MAX_SPD);
        terminal  = (timer == TIMER_LAST);
    end

    // State and registered outputs; rst overrides every button.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            target_speed <= '0;
            fuel         <= '0;
            fuel_upd     <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            target_speed <= target_nxt;
            fuel         <= fuel_nxt;
            fuel_upd     <= fuel_upd_nxt;
        end
    end

    // Next-state decode from the prioritised buttons.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (set_go) state_nxt = CRUISE;
            end
            CRUISE: begin
                if (cancel)     state_nxt = IDLE;
                else if (brake) state_nxt = SUSPEND;
            end
            SUSPEND: begin
                if (cancel)                                  state_nxt = IDLE;
                else if (set_go)                             state_nxt = CRUISE;
                else if (!brake && !set && resume)           state_nxt = CRUISE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of target, timer and fuel. Any transition out of CRUISE takes
    // precedence over a pending terminal-count update.
    always_comb begin
        target_nxt   = target_speed;
        timer_nxt    = '0;
        fuel_nxt     = '0;
        fuel_upd_nxt = 1'b0;
        entering     = (state_nxt == CRUISE) && (state != CRUISE);
        recapture    = (state == CRUISE) && set_go;

        if (cancel) begin
            target_nxt = '0;
        end else if (set_go) begin
            target_nxt = current_speed;
        end else if (adjust) begin
            target_nxt = inc ? target_up : target_dn;
        end

        if (state_nxt == CRUISE) begin
            if (entering) begin
                fuel_nxt = BASE_CMD;
            end else if (recapture) begin
                fuel_nxt = fuel;
            end else if (terminal) begin
                fuel_nxt     = law_fuel;
                fuel_upd_nxt = 1'b1;
            end else begin
                fuel_nxt  = fuel;
                timer_nxt = timer + TIMER_W'(1);
            end
        end
    end

    // engaged follows the registered state directly.
    assign engaged = (state == CRUISE);

endmodule

// File: tb/tb_cruise_controller.sv
// Directed, table-driven bench for cruise_controller with default parameters.
module tb_cruise_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] current_speed;
    logic       set, resume, cancel, brake, inc, dec;
    logic [3:0] fuel;
    logic [7:0] target_speed;
    logic       engaged;
    logic       fuel_upd;

    int errors = 0;
    int checks = 0;

    cruise_controller dut (
        .clk           (clk),
        .rst           (rst),
        .current_speed (current_speed),
        .set           (set),
        .resume        (resume),
        .cancel        (cancel),
        .brake         (brake),
        .inc           (inc),
        .dec           (dec),
        .fuel          (fuel),
        .target_speed  (target_speed),
        .engaged       (engaged),
        .fuel_upd      (fuel_upd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] speed;
        logic       set, resume, cancel, brake, inc, dec;
        int         n;
        logic [3:0] fuel;
        logic [7:0] tgt;
        logic       eng;
        logic       upd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [7:0] sp,
                                input logic s, input logic rs, input logic c,
                                input logic b, input logic i, input logic d,
                                input int n, input logic [3:0] f, input logic [7:0] t,
                                input logic e, input logic u);
        vec_t v;
        v.rst = r; v.speed = sp; v.set = s; v.resume = rs; v.cancel = c;
        v.brake = b; v.inc = i; v.dec = d; v.n = n;
        v.fuel = f; v.tgt = t; v.eng = e; v.upd = u;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] sp, input logic s,
                         input logic rs, input logic c, input logic b,
                         input logic i, input logic d);
        rst = r; current_speed = sp; set = s; resume = rs;
        cancel = c; brake = b; inc = i; dec = d;
    endtask

    initial begin
        drive(1'b1, 8'd0, 0, 0, 0, 0, 0, 0);

        //                rst speed set res can brk inc dec  n  fuel tgt eng upd
        vecs.push_back(mk(1, 100, 1, 1, 0, 0, 1, 0,  3,  0,   0, 0, 0)); // 0 reset with buttons
        vecs.push_back(mk(0, 100, 1, 0, 0, 0, 0, 0,  1,  4, 100, 1, 0)); // 1 engage
        vecs.push_back(mk(0,  90, 0, 0, 0, 0, 0, 0, 15,  4, 100, 1, 0)); // 2 timer at 15
        vecs.push_back(mk(0,  90, 0, 0, 0, 0, 0, 0,  1,  9, 100, 1, 1)); // 3 first update
        vecs.push_back(mk(0,  90, 0, 0, 0, 0, 0, 0,  1,  9, 100, 1, 0)); // 4 pulse ends
        vecs.push_back(mk(0, 120, 0, 0, 0, 0, 0, 0, 15,  0, 100, 1, 1)); // 5 clamp low
        vecs.push_back(mk(0,  60, 0, 0, 0, 0, 0, 0, 16, 15, 100, 1, 1)); // 6 clamp high
        vecs.push_back(mk(0,  60, 0, 0, 0, 1, 0, 0,  1,  0, 100, 0, 0)); // 7 brake
        vecs.push_back(mk(0,  60, 0, 1, 0, 1, 0, 0,  1,  0, 100, 0, 0)); // 8 resume under brake
        vecs.push_back(mk(0,  60, 0, 1, 0, 0, 0, 0,  1,  4, 100, 1, 0)); // 9 resume
        vecs.push_back(mk(0, 199, 1, 0, 0, 0, 0, 0,  1,  4, 199, 1, 0)); // 10 recapture
        vecs.push_back(mk(0, 199, 0, 0, 0, 0, 1, 0,  1,  4, 200, 1, 0)); // 11 inc
        vecs.push_back(mk(0, 199, 0, 0, 0, 0, 1, 0,  1,  4, 200, 1, 0)); // 12 inc saturates
        vecs.push_back(mk(0,  31, 1, 0, 0, 0, 0, 0,  1,  4,  31, 1, 0)); // 13 recapture 31
        vecs.push_back(mk(0,  31, 0, 0, 0, 0, 0, 1,  1,  4,  30, 1, 0)); // 14 dec
        vecs.push_back(mk(0,  31, 0, 0, 0, 0, 0, 1,  1,  4,  30, 1, 0)); // 15 dec saturates
        vecs.push_back(mk(0,  31, 0, 0, 0, 0, 1, 1,  1,  4,  30, 1, 0)); // 16 inc&dec
        vecs.push_back(mk(0,  31, 0, 0, 1, 0, 0, 0,  1,  0,   0, 0, 0)); // 17 cancel
        vecs.push_back(mk(0,  20, 1, 0, 0, 0, 0, 0,  1,  0,   0, 0, 0)); // 18 set too slow
        vecs.push_back(mk(0, 201, 1, 0, 0, 0, 0, 0,  1,  0,   0, 0, 0)); // 19 set too fast
        vecs.push_back(mk(0, 200, 1, 0, 0, 0, 0, 0,  1,  4, 200, 1, 0)); // 20 set at max
        vecs.push_back(mk(0, 200, 0, 0, 1, 1, 0, 0,  1,  0,   0, 0, 0)); // 21 cancel+brake
        vecs.push_back(mk(0, 100, 1, 0, 0, 0, 0, 0,  1,  4, 100, 1, 0)); // 22 re-engage
        vecs.push_back(mk(1,  50, 1, 0, 0, 0, 1, 0,  1,  0,   0, 0, 0)); // 23 reset mid-cruise
        vecs.push_back(mk(0,  50, 0, 0, 0, 0, 0, 0,  2,  0,   0, 0, 0)); // 24 stays idle
        vecs.push_back(mk(0, 100, 1, 0, 0, 0, 0, 0,  1,  4, 100, 1, 0)); // 25 engage
        vecs.push_back(mk(0,  80, 0, 0, 0, 0, 0, 0, 15,  4, 100, 1, 0)); // 26 timer at 15
        vecs.push_back(mk(0,  80, 0, 0, 0, 1, 0, 0,  1,  0, 100, 0, 0)); // 27 brake on terminal
        vecs.push_back(mk(0,  80, 0, 0, 0, 0, 1, 0,  1,  0, 100, 0, 0)); // 28 inc in suspend
        vecs.push_back(mk(0,  80, 1, 0, 0, 0, 0, 0,  1,  4,  80, 1, 0)); // 29 set from suspend

        foreach (vecs[k]) begin
            for (int c = 0; c < vecs[k].n; c++) begin
                drive(vecs[k].rst, vecs[k].speed, vecs[k].set, vecs[k].resume,
                      vecs[k].cancel, vecs[k].brake, vecs[k].inc, vecs[k].dec);
                @(posedge clk);
                #1;
            end
            check($sformatf("row%0d.fuel", k),    fuel,         vecs[k].fuel);
            check($sformatf("row%0d.target", k),  target_speed, vecs[k].tgt);
            check($sformatf("row%0d.engaged", k), engaged,      vecs[k].eng);
            check($sformatf("row%0d.fuel_upd", k), fuel_upd,    vecs[k].upd);
        end

        // Steady cruise at zero error: fuel_upd pulses exactly every 16 clocks.
        drive(1'b0, 8'd150, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(1'b0, 8'd150, 0, 0, 0, 0, 0, 0);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            check($sformatf("period.upd%0d", cyc), fuel_upd, (cyc % 16 == 0) ? 1 : 0);
            check($sformatf("period.fuel%0d", cyc), fuel, 4);
        end
        check("period.target", target_speed, 150);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
